// File: rtl/mmu_cmd_sequencer.sv
// mmu_cmd_sequencer: the only driver of the MMU command port.
// It chooses between the exception unit and the CPU, runs each operation as a
// short fixed sequence of MMU commands, and owns the hardware Random counter
// that picks the victim entry for random TLB writes.
// Optional build macro: MMU_SEQ_STATS_EN adds the stat_tlbw / stat_exc counters.
// All outputs are registered. Each state computes the outputs that become
// visible in the following cycle.

`ifndef MMU_CMD_T
`define MMU_CMD_T              logic [2:0]
`define MMU_CMD_NONE           3'd0
`define MMU_CMD_READ_REG       3'd1
`define MMU_CMD_WRITE_REG      3'd2
`define MMU_CMD_READ_TLB       3'd3
`define MMU_CMD_WRITE_TLB      3'd4
`define MMU_CMD_WRITE_TLB_RANDOM 3'd5
`define MMU_CMD_PROB_TLB       3'd6
`endif

`ifndef MMU_REG_T
`define MMU_REG_T              logic [4:0]
`define MMU_REG_INDEX          5'd0
`define MMU_REG_RANDOM         5'd1
`define MMU_REG_WIRED          5'd6
`define MMU_REG_ENTRYHI        5'd10
`endif

module mmu_cmd_sequencer #(
  parameter int ENTRY_ADDR_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic                        cpu_req,
  input  logic [2:0]                  cpu_op,
  input  `MMU_REG_T                   cpu_reg,
  input  logic [31:0]                 cpu_wdata,
  output logic                        cpu_ack,
  input  logic                        exc_req,
  input  `MMU_REG_T                   exc_reg,
  input  logic [31:0]                 exc_wdata,
  output logic                        exc_ack,
  output logic                        done,
  output logic                        done_src,
  output logic [31:0]                 rdata,
  output logic                        busy,
  output `MMU_CMD_T                   mmu_cmd,
  output `MMU_REG_T                   mmu_reg,
  output logic [31:0]                 mmu_dataIn,
  input  logic [31:0]                 mmu_dataOut,
  output logic [ENTRY_ADDR_WIDTH-1:0] random_val
`ifdef MMU_SEQ_STATS_EN
  ,
  output logic [31:0]                 stat_tlbw,
  output logic [31:0]                 stat_exc
`endif
);

  localparam logic [2:0] OP_MFC0  = 3'd0;
  localparam logic [2:0] OP_MTC0  = 3'd1;
  localparam logic [2:0] OP_TLBR  = 3'd2;
  localparam logic [2:0] OP_TLBWI = 3'd3;
  localparam logic [2:0] OP_TLBWR = 3'd4;
  localparam logic [2:0] OP_TLBP  = 3'd5;

  // Highest entry index, the Random reload value.
  localparam logic [ENTRY_ADDR_WIDTH-1:0] RAND_TOP = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RDWAIT,
    S_RANDWR,
    S_FIN
  } state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  op_q, op_d;
  logic                        src_q, src_d;       // 1 = exception unit
  logic [4:0]                  reg_q, reg_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic                        cpu_ack_q, cpu_ack_d;
  logic                        exc_ack_q, exc_ack_d;
  logic                        done_q, done_d;
  logic                        done_src_q, done_src_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic                        busy_q, busy_d;
  logic [2:0]                  cmd_q, cmd_d;
  logic [4:0]                  mreg_q, mreg_d;
  logic [31:0]                 mdata_q, mdata_d;
  logic [ENTRY_ADDR_WIDTH-1:0] random_q, random_d;
  logic [ENTRY_ADDR_WIDTH-1:0] wired_q, wired_d;
  logic                        wired_wr;

  // A WIRED write takes effect in the cycle its WRITE_REG is on the MMU port;
  // that is when this sequencer sits in FIN for a register write.
  assign wired_wr = (state_q == S_FIN) && (op_q == OP_MTC0) &&
                    (reg_q == `MMU_REG_WIRED);

  // Random counter: counts down toward wired, reloads at the top; WIRED writes win.
  always_comb begin
    wired_d  = wired_q;
    random_d = random_q;
    if (wired_wr) begin
      wired_d  = wdata_q[ENTRY_ADDR_WIDTH-1:0];
      random_d = RAND_TOP;
    end else if ((wired_q >= RAND_TOP) || (random_q <= wired_q)) begin
      random_d = RAND_TOP;
    end else begin
      random_d = random_q - 1'b1;
    end
  end

  // Sequencer next state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    cpu_ack_d  = 1'b0;
    exc_ack_d  = 1'b0;
    done_d     = 1'b0;
    done_src_d = done_src_q;
    rdata_d    = rdata_q;
    cmd_d      = `MMU_CMD_NONE;
    mreg_d     = mreg_q;
    mdata_d    = mdata_q;

    unique case (state_q)
      S_IDLE: begin
        // The exception unit always wins a same-cycle tie.
        if (exc_req) begin
          exc_ack_d = 1'b1;
          src_d     = 1'b1;
          op_d      = OP_MTC0;
          reg_d     = exc_reg;
          wdata_d   = exc_wdata;
          state_d   = S_ISSUE;
        end else if (cpu_req) begin
          cpu_ack_d = 1'b1;
          src_d     = 1'b0;
          op_d      = cpu_op;
          reg_d     = cpu_reg;
          wdata_d   = cpu_wdata;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_FIN;
        unique case (op_q)
          OP_MTC0: begin
            cmd_d   = `MMU_CMD_WRITE_REG;
            mreg_d  = reg_q;
            mdata_d = wdata_q;
          end
          OP_MFC0: begin
            cmd_d   = `MMU_CMD_READ_REG;
            mreg_d  = reg_q;
            state_d = S_RDWAIT;
          end
          OP_TLBR:  cmd_d = `MMU_CMD_READ_TLB;
          OP_TLBWI: cmd_d = `MMU_CMD_WRITE_TLB;
          OP_TLBP:  cmd_d = `MMU_CMD_PROB_TLB;
          OP_TLBWR: begin
            // Random value shown alongside this command is the one written.
            cmd_d   = `MMU_CMD_WRITE_REG;
            mreg_d  = `MMU_REG_RANDOM;
            mdata_d = {{(32-ENTRY_ADDR_WIDTH){1'b0}}, random_d};
            state_d = S_RANDWR;
          end
          default: begin
            // Reserved opcode: complete immediately without touching the MMU.
            done_d     = 1'b1;
            done_src_d = src_q;
            state_d    = S_IDLE;
          end
        endcase
      end
      S_RDWAIT: begin
        // MMU read data is registered; wait one cycle for it.
        state_d = S_FIN;
      end
      S_RANDWR: begin
        cmd_d   = `MMU_CMD_WRITE_TLB_RANDOM;
        state_d = S_FIN;
      end
      S_FIN: begin
        done_d     = 1'b1;
        done_src_d = src_q;
        if (op_q == OP_MFC0) begin
          rdata_d = mmu_dataOut;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      src_q      <= 1'b0;
      reg_q      <= 5'd0;
      wdata_q    <= 32'd0;
      cpu_ack_q  <= 1'b0;
      exc_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      done_src_q <= 1'b0;
      rdata_q    <= 32'd0;
      busy_q     <= 1'b0;
      cmd_q      <= `MMU_CMD_NONE;
      mreg_q     <= 5'd0;
      mdata_q    <= 32'd0;
      random_q   <= RAND_TOP;
      wired_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      cpu_ack_q  <= cpu_ack_d;
      exc_ack_q  <= exc_ack_d;
      done_q     <= done_d;
      done_src_q <= done_src_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      cmd_q      <= cmd_d;
      mreg_q     <= mreg_d;
      mdata_q    <= mdata_d;
      random_q   <= random_d;
      wired_q    <= wired_d;
    end
  end

`ifdef MMU_SEQ_STATS_EN
  logic [31:0] stat_tlbw_q, stat_exc_q;

  // Completion counters, bumped on the FIN cycle of the counted operations.
  always_ff @(posedge clk) begin
    if (!res) begin
      stat_tlbw_q <= 32'd0;
      stat_exc_q  <= 32'd0;
    end else if (state_q == S_FIN) begin
      if (!src_q && ((op_q == OP_TLBWI) || (op_q == OP_TLBWR))) begin
        stat_tlbw_q <= stat_tlbw_q + 32'd1;
      end
      if (src_q) begin
        stat_exc_q <= stat_exc_q + 32'd1;
      end
    end
  end

  assign stat_tlbw = stat_tlbw_q;
  assign stat_exc  = stat_exc_q;
`endif

  assign cpu_ack    = cpu_ack_q;
  assign exc_ack    = exc_ack_q;
  assign done       = done_q;
  assign done_src   = done_src_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign mmu_cmd    = cmd_q;
  assign mmu_reg    = mreg_q;
  assign mmu_dataIn = mdata_q;
  assign random_val = random_q;

endmodule

// File: tb/tb_mmu_cmd_sequencer.sv
// Directed testbench for mmu_cmd_sequencer with a small registered MMU model.
// Optional build macro: MMU_SEQ_STATS_EN (stat ports are connected when set).

`ifndef MMU_CMD_T
`define MMU_CMD_T              logic [2:0]
`define MMU_CMD_NONE           3'd0
`define MMU_CMD_READ_REG       3'd1
`define MMU_CMD_WRITE_REG      3'd2
`define MMU_CMD_READ_TLB       3'd3
`define MMU_CMD_WRITE_TLB      3'd4
`define MMU_CMD_WRITE_TLB_RANDOM 3'd5
`define MMU_CMD_PROB_TLB       3'd6
`endif

`ifndef MMU_REG_T
`define MMU_REG_T              logic [4:0]
`define MMU_REG_INDEX          5'd0
`define MMU_REG_RANDOM         5'd1
`define MMU_REG_WIRED          5'd6
`define MMU_REG_ENTRYHI        5'd10
`endif

module tb_mmu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        cpu_req = 1'b0;
  logic [2:0]  cpu_op = 3'd0;
  logic [4:0]  cpu_reg = 5'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_ack;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_reg = 5'd0;
  logic [31:0] exc_wdata = 32'd0;
  logic        exc_ack;
  logic        done;
  logic        done_src;
  logic [31:0] rdata;
  logic        busy;
  logic [2:0]  mmu_cmd;
  logic [4:0]  mmu_reg;
  logic [31:0] mmu_dataIn;
  logic [31:0] mmu_dataOut = 32'd0;
  logic [3:0]  random_val;
`ifdef MMU_SEQ_STATS_EN
  logic [31:0] stat_tlbw;
  logic [31:0] stat_exc;
`endif

  int checks = 0;
  int passes = 0;

  logic [31:0] mregs [32];

  mmu_cmd_sequencer #(.ENTRY_ADDR_WIDTH(4)) dut (
    .clk(clk), .res(res),
    .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_reg(cpu_reg), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .exc_req(exc_req), .exc_reg(exc_reg), .exc_wdata(exc_wdata), .exc_ack(exc_ack),
    .done(done), .done_src(done_src), .rdata(rdata), .busy(busy),
    .mmu_cmd(mmu_cmd), .mmu_reg(mmu_reg), .mmu_dataIn(mmu_dataIn),
    .mmu_dataOut(mmu_dataOut), .random_val(random_val)
`ifdef MMU_SEQ_STATS_EN
    , .stat_tlbw(stat_tlbw), .stat_exc(stat_exc)
`endif
  );

  always #5 clk = ~clk;

  // MMU register file model: read data appears the cycle after READ_REG.
  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
  end

  always @(posedge clk) begin
    if (mmu_cmd == `MMU_CMD_WRITE_REG) mregs[mmu_reg] <= mmu_dataIn;
    if (mmu_cmd == `MMU_CMD_READ_REG) mmu_dataOut <= mregs[mmu_reg];
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a CPU request and return in the cycle its ack is visible.
  task automatic cpu_start(input logic [2:0] op, input logic [4:0] r,
                           input logic [31:0] d, input string name);
    bit got;
    got = 0;
    cpu_op = op; cpu_reg = r; cpu_wdata = d; cpu_req = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (cpu_ack === 1'b1) got = 1;
    end
    cpu_req = 1'b0;
    checks++;
    if (!got) $display("FAIL %s_ack got=none exp=ack_within_8", name);
    else passes++;
    $display("txn cpu %s op=%0d reg=%0d data=%08h", name, op, r, d);
  endtask

  task automatic test_reset();
    res = 1'b0;
    tick(); tick(); tick();
    checks++; if (random_val !== 4'd15) $display("FAIL rst_random got=%0d exp=15", random_val); else passes++;
    checks++; if (mmu_cmd !== `MMU_CMD_NONE) $display("FAIL rst_cmd got=%0d exp=0", mmu_cmd); else passes++;
    checks++; if ({busy, done, done_src, cpu_ack, exc_ack} !== 5'b0) $display("FAIL rst_flags got=%05b exp=00000", {busy, done, done_src, cpu_ack, exc_ack}); else passes++;
    checks++; if (rdata !== 32'd0 || mmu_dataIn !== 32'd0 || mmu_reg !== 5'd0) $display("FAIL rst_data got=%08h/%08h/%0d exp=0/0/0", rdata, mmu_dataIn, mmu_reg); else passes++;
    res = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_idle_random();
    logic [3:0] exp_r;
    exp_r = 4'd15;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_r = (exp_r == 4'd0) ? 4'd15 : exp_r - 4'd1;
      checks++; if (random_val !== exp_r) $display("FAIL idle_random[%0d] got=%0d exp=%0d", i, random_val, exp_r); else passes++;
      checks++; if (mmu_cmd !== `MMU_CMD_NONE) $display("FAIL idle_cmd[%0d] got=%0d exp=0", i, mmu_cmd); else passes++;
    end
    $display("txn idle 20 cycles");
  endtask

  task automatic test_reserved();
    cpu_start(3'd6, 5'd0, 32'd0, "reserved");
    checks++; if (busy !== 1'b1) $display("FAIL rsv_busy got=%0b exp=1", busy); else passes++;
    tick();
    checks++; if (done !== 1'b1 || done_src !== 1'b0) $display("FAIL rsv_done got=%0b/%0b exp=1/0", done, done_src); else passes++;
    checks++; if (mmu_cmd !== `MMU_CMD_NONE || busy !== 1'b0) $display("FAIL rsv_cmd got=%0d/%0b exp=0/0", mmu_cmd, busy); else passes++;
    tick();
    checks++; if (done !== 1'b0) $display("FAIL rsv_done_pulse got=%0b exp=0", done); else passes++;
  endtask

  task automatic test_wired();
    logic [3:0] exp_r;
    cpu_start(3'd1, `MMU_REG_WIRED, 32'h5, "mtc0_wired");
    tick();
    checks++; if (mmu_cmd !== `MMU_CMD_WRITE_REG || mmu_reg !== `MMU_REG_WIRED || mmu_dataIn !== 32'h5) $display("FAIL wired_issue got=%0d/%0d/%08h exp=2/6/00000005", mmu_cmd, mmu_reg, mmu_dataIn); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL wired_early_done got=%0b exp=0", done); else passes++;
    tick();
    checks++; if (random_val !== 4'd15) $display("FAIL wired_reload got=%0d exp=15", random_val); else passes++;
    checks++; if (done !== 1'b1 || done_src !== 1'b0 || busy !== 1'b0) $display("FAIL wired_done got=%0b/%0b/%0b exp=1/0/0", done, done_src, busy); else passes++;
    exp_r = 4'd15;
    for (int i = 0; i < 22; i++) begin
      tick();
      exp_r = (exp_r <= 4'd5) ? 4'd15 : exp_r - 4'd1;
      checks++; if (random_val !== exp_r) $display("FAIL wired_random[%0d] got=%0d exp=%0d", i, random_val, exp_r); else passes++;
    end
  endtask

  task automatic test_mfc0();
    cpu_start(3'd1, `MMU_REG_ENTRYHI, 32'h12345000, "mtc0_entryhi");
    tick(); tick();
    checks++; if (done !== 1'b1) $display("FAIL mtc0_done got=%0b exp=1", done); else passes++;
    cpu_start(3'd0, `MMU_REG_ENTRYHI, 32'd0, "mfc0_entryhi");
    tick();
    checks++; if (mmu_cmd !== `MMU_CMD_READ_REG || mmu_reg !== `MMU_REG_ENTRYHI) $display("FAIL mfc0_issue got=%0d/%0d exp=1/10", mmu_cmd, mmu_reg); else passes++;
    tick();
    checks++; if (mmu_cmd !== `MMU_CMD_NONE || done !== 1'b0) $display("FAIL mfc0_wait got=%0d/%0b exp=0/0", mmu_cmd, done); else passes++;
    tick();
    checks++; if (done !== 1'b1 || done_src !== 1'b0) $display("FAIL mfc0_done got=%0b/%0b exp=1/0", done, done_src); else passes++;
    checks++; if (rdata !== 32'h12345000) $display("FAIL mfc0_rdata got=%08h exp=12345000", rdata); else passes++;
    tick();
    checks++; if (done !== 1'b0 || rdata !== 32'h12345000) $display("FAIL mfc0_hold got=%0b/%08h exp=0/12345000", done, rdata); else passes++;
  endtask

  task automatic test_tlbwr();
    bit seen;
    seen = 0;
    // Request when Random shows 11 so that it reads 9 in the issue cycle.
    for (int i = 0; i < 30 && !seen; i++) begin
      if (random_val === 4'd11) seen = 1;
      else tick();
    end
    checks++; if (!seen) $display("FAIL tlbwr_wait got=none exp=random_11"); else passes++;
    cpu_start(3'd4, 5'd0, 32'd0, "tlbwr");
    tick();
    checks++; if (mmu_cmd !== `MMU_CMD_WRITE_REG || mmu_reg !== `MMU_REG_RANDOM) $display("FAIL tlbwr_issue got=%0d/%0d exp=2/1", mmu_cmd, mmu_reg); else passes++;
    checks++; if (mmu_dataIn !== 32'h9 || random_val !== 4'd9) $display("FAIL tlbwr_data got=%08h/%0d exp=00000009/9", mmu_dataIn, random_val); else passes++;
    tick();
    checks++; if (mmu_cmd !== `MMU_CMD_WRITE_TLB_RANDOM || done !== 1'b0) $display("FAIL tlbwr_randwr got=%0d/%0b exp=5/0", mmu_cmd, done); else passes++;
    checks++; if (random_val !== 4'd8) $display("FAIL tlbwr_nochange got=%0d exp=8", random_val); else passes++;
    tick();
    checks++; if (done !== 1'b1 || done_src !== 1'b0 || mmu_cmd !== `MMU_CMD_NONE) $display("FAIL tlbwr_done got=%0b/%0b/%0d exp=1/0/0", done, done_src, mmu_cmd); else passes++;
  endtask

  task automatic test_arbitration();
    exc_reg = `MMU_REG_ENTRYHI; exc_wdata = 32'hABCDE000; exc_req = 1'b1;
    cpu_op = 3'd3; cpu_reg = 5'd0; cpu_wdata = 32'd0; cpu_req = 1'b1;
    tick();
    checks++; if (exc_ack !== 1'b1 || cpu_ack !== 1'b0) $display("FAIL arb_ack got=%0b/%0b exp=1/0", exc_ack, cpu_ack); else passes++;
    exc_req = 1'b0;
    $display("txn exc write reg=%0d data=%08h", exc_reg, exc_wdata);
    tick();
    checks++; if (mmu_cmd !== `MMU_CMD_WRITE_REG || mmu_reg !== `MMU_REG_ENTRYHI || mmu_dataIn !== 32'hABCDE000) $display("FAIL arb_exc_issue got=%0d/%0d/%08h exp=2/10/abcde000", mmu_cmd, mmu_reg, mmu_dataIn); else passes++;
    tick();
    checks++; if (done !== 1'b1 || done_src !== 1'b1 || cpu_ack !== 1'b0) $display("FAIL arb_exc_done got=%0b/%0b/%0b exp=1/1/0", done, done_src, cpu_ack); else passes++;
    tick();
    checks++; if (cpu_ack !== 1'b1 || exc_ack !== 1'b0) $display("FAIL arb_cpu_ack got=%0b/%0b exp=1/0", cpu_ack, exc_ack); else passes++;
    cpu_req = 1'b0;
    $display("txn cpu tlbwi after exc");
    tick();
    checks++; if (mmu_cmd !== `MMU_CMD_WRITE_TLB) $display("FAIL arb_tlbwi_cmd got=%0d exp=4", mmu_cmd); else passes++;
    tick();
    checks++; if (done !== 1'b1 || done_src !== 1'b0) $display("FAIL arb_tlbwi_done got=%0b/%0b exp=1/0", done, done_src); else passes++;
  endtask

  task automatic test_reset_midop();
    cpu_start(3'd0, `MMU_REG_ENTRYHI, 32'd0, "mfc0_abort");
    tick();
    checks++; if (mmu_cmd !== `MMU_CMD_READ_REG) $display("FAIL abort_issue got=%0d exp=1", mmu_cmd); else passes++;
    tick();
    res = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_flags got=%0b/%0b exp=0/0", done, busy); else passes++;
    checks++; if (rdata !== 32'd0 || mmu_cmd !== `MMU_CMD_NONE) $display("FAIL abort_state got=%08h/%0d exp=0/0", rdata, mmu_cmd); else passes++;
    res = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || mmu_cmd !== `MMU_CMD_NONE || random_val !== 4'd14) $display("FAIL abort_after got=%0b/%0d/%0d exp=0/0/14", done, mmu_cmd, random_val); else passes++;
    $display("txn reset during mfc0");
  endtask

  initial begin
    #1;
    test_reset();
    test_idle_random();
    test_reserved();
    test_wired();
    test_mfc0();
    test_tlbwr();
    test_arbitration();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mmu_cmd_sequencer.md
Name: mmu_cmd_sequencer

Overview:
- Sits between the CP0/pipeline and the MMU command port. It is the only driver of the MMU's mmu_cmd, mmu_reg and mmu_dataIn inputs.
- Arbitrates between two requesters: the exception unit (register writes on TLB fault) and the CPU (CP0 moves and TLB instructions).
- Sequences multi-cycle operations and owns the hardware Random counter that selects the victim entry for random TLB writes.

Parameters:
ENTRY_ADDR_WIDTH, 4, log2 of TLB entry count; ENTRY_COUNT = 1<<ENTRY_ADDR_WIDTH.

Ports:
clk  in  1  clock; all state updates on rising edge
res  in  1  synchronous reset, active-low (0 = reset)
cpu_req  in  1  CPU request; held high until cpu_ack
cpu_op  in  3  0=MFC0, 1=MTC0, 2=TLBR, 3=TLBWI, 4=TLBWR, 5=TLBP; 6,7 reserved
cpu_reg  in  `MMU_REG_T  register for MFC0/MTC0
cpu_wdata  in  32  MTC0 data
cpu_ack  out  1  one-cycle pulse: CPU request accepted
exc_req  in  1  exception-unit register-write request; held until exc_ack
exc_reg  in  `MMU_REG_T  register to write
exc_wdata  in  32  data to write
exc_ack  out  1  one-cycle pulse: exception request accepted
done  out  1  one-cycle pulse: operation complete
done_src  out  1  source of completed operation: 0=CPU, 1=exception unit
rdata  out  32  MFC0 result; valid while done=1 for MFC0, holds until next MFC0 completes
busy  out  1  high in every state except IDLE
mmu_cmd  out  `MMU_CMD_T  to MMU
mmu_reg  out  `MMU_REG_T  to MMU
mmu_dataIn  out  32  to MMU
mmu_dataOut  in  32  from MMU; registered, valid the cycle after READ_REG
random_val  out  ENTRY_ADDR_WIDTH  current Random counter

Behaviour:
- Reset (res=0 at clock edge):
  - State=IDLE; mmu_cmd=`MMU_CMD_NONE; mmu_reg=0; mmu_dataIn=0.
  - cpu_ack, exc_ack, done, done_src, busy all 0; rdata=0.
  - Random=ENTRY_COUNT-1; internal wired=0.
  - Reset mid-operation aborts the operation with no done pulse and no further MMU commands.
- All outputs are registered. mmu_cmd is `MMU_CMD_NONE in any cycle not listed below.
- Arbitration (IDLE only): exc_req wins over cpu_req in the same cycle. The winner's ack pulses in the accept cycle and its operands are latched. The loser waits, unacked.
- Reserved cpu_op values: acked, then done next cycle with no MMU command.
- States: IDLE, ISSUE, RDWAIT, RANDWR, FIN.
- Accept cycle: IDLE -> ISSUE.
- ISSUE cycle, by operation:
  - MTC0 / exception write: mmu_cmd=WRITE_REG, mmu_reg and mmu_dataIn from the latched operands; -> FIN.
  - MFC0: mmu_cmd=READ_REG; -> RDWAIT.
  - RDWAIT: capture mmu_dataOut into rdata; -> FIN.
  - TLBR: mmu_cmd=READ_TLB; -> FIN.
  - TLBWI: mmu_cmd=WRITE_TLB; -> FIN.
  - TLBP: mmu_cmd=PROB_TLB; -> FIN.
  - TLBWR: mmu_cmd=WRITE_REG, mmu_reg=RANDOM, mmu_dataIn = zero-extended Random value sampled in this cycle; -> RANDWR.
  - RANDWR: mmu_cmd=WRITE_TLB_RANDOM; -> FIN.
- FIN: done=1, done_src set; -> IDLE. A new request may be accepted in the following cycle.
- Latency from ack to done:
  - 2 cycles: MTC0, TLBR, TLBWI, TLBP, exception write.
  - 3 cycles: MFC0, TLBWR.
- Random counter:
  - Decrements every cycle outside reset.
  - If Random <= wired, the next value is ENTRY_COUNT-1.
  - If wired >= ENTRY_COUNT-1, Random stays at ENTRY_COUNT-1.
- Any write to WIRED (CPU or exception unit), in its ISSUE cycle: wired <= wdata[ENTRY_ADDR_WIDTH-1:0] and Random <= ENTRY_COUNT-1. This overrides the decrement.
- A write to RANDOM is forwarded to the MMU but does not change the counter.

Optional Feature:
MMU_SEQ_STATS_EN:
- Defined: adds output stat_tlbw (32 bits) and output stat_exc (32 bits).
  - stat_tlbw increments once per completed TLBWI or TLBWR.
  - stat_exc increments once per completed exception-unit write.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists.

Test Plan:
- Reset then 20 idle cycles, ENTRY_ADDR_WIDTH=4 -> random_val goes 15,14,...,0 then wraps to 15; mmu_cmd stays NONE throughout.
- CPU MTC0 WIRED with 0x5 -> ack, WRITE_REG in ISSUE, random_val=15 in the next cycle, then cycles over 15..5 only; done at ack+2.
- CPU MFC0 ENTRYHI after a prior MTC0 ENTRYHI=0x12345000 -> READ_REG one cycle, rdata=0x12345000 with done at ack+3, done_src=0.
- CPU TLBWR with random_val=9 sampled in ISSUE -> WRITE_REG RANDOM with dataIn=0x9, next cycle WRITE_TLB_RANDOM, done at ack+3.
- exc_req (ENTRYHI=0xABCDE000) and cpu_req TLBWI raised in the same cycle -> exc_ack first, done with done_src=1; cpu_ack in the cycle after that done; WRITE_TLB issued next.
- res=0 asserted in the RDWAIT cycle of an MFC0 -> no done pulse, rdata=0, busy=0, mmu_cmd=NONE next cycle.
